lut_digit_mac: RTL and testbench
================================

LUT_DIGIT_MAC -- requirements
Module: lut_digit_mac

Interface
REQ-001 SHALL have parameter A_W, default 8, meaning multiplicand width in bits (signed two's complement).
REQ-002 SHALL have parameter ND, default 3, meaning number of coded multiplier digits per operation.
REQ-003 SHALL use derived product width P_W = A_W + 3*ND (17 at defaults), not a separate parameter.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 a_valid  input  1  multiplicand offered.
REQ-008 a_ready  output  1  block accepts multiplicand; high only in IDLE.
REQ-009 a  input  A_W  signed multiplicand.
REQ-010 dig_valid  input  1  coded digit offered by the input-coding stage.
REQ-011 dig_ready  output  1  block consumes digit; high only in DIGIT.
REQ-012 dig  input  4  coded digit: dig[3] sign, dig[2:0] magnitude 0..7.
REQ-013 p_valid  output  1  product available.
REQ-014 p_ready  input  1  downstream accepts product.
REQ-015 p  output  P_W  signed product.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL interpret each digit as value = dig[3] ? -dig[2:0] : +dig[2:0]; "-0" equals 0.
REQ-018 SHALL consume digits least-significant first; digit k has weight 8^k, k = 0..ND-1.
REQ-019 SHALL compute p = a * sum(value_k * 8^k), exact, no saturation, sign-extended to P_W.
REQ-020 SHALL implement FSM states IDLE, BUILD, DIGIT, DONE.
REQ-021 IDLE: on a_valid && a_ready edge, capture a; LUT[0]=0, LUT[1]=a; clear accumulator and digit counter; go to BUILD.
REQ-022 BUILD: one entry per cycle, LUT[m] = LUT[m-1] + a for m = 2..7, using one adder; exactly 6 cycles; then go to DIGIT.
REQ-023 LUT entries SHALL be A_W+3 bits signed.
REQ-024 DIGIT: on each dig_valid && dig_ready edge, acc += (sign ? -LUT[mag] : LUT[mag]) << 3k; increment k.
REQ-025 DIGIT SHALL stall indefinitely while dig_valid is low, with no state change.
REQ-026 After the ND-th digit is accepted, go to DONE; p_valid SHALL be high the following cycle.
REQ-027 With no stalls, p_valid SHALL rise exactly 6+ND clock edges after the a-accept edge (9 at defaults).
REQ-028 DONE: p and p_valid SHALL be held stable until p_ready; on p_valid && p_ready edge, go to IDLE and deassert p_valid.
REQ-029 a_valid asserted outside IDLE SHALL be ignored; no back-to-back overlap of operations.
REQ-030 dig_valid asserted outside DIGIT SHALL be ignored; no digit consumed.
REQ-031 p SHALL be 0 whenever p_valid is low.

Reset
REQ-032 rst SHALL asynchronously force IDLE, a_ready=1, dig_ready=0, p_valid=0, p=0, busy=0, and clear accumulator, counter and LUT.
REQ-033 rst asserted mid-operation (BUILD/DIGIT/DONE) SHALL discard partial results; the first operation after release SHALL be correct.
REQ-034 a_ready SHALL go high the first cycle after rst deasserts.

Verification
REQ-035 a=5, digits {+3,+2,+1}, no stalls -> p=415, p_valid 9 edges after accept.
REQ-036 a=-128, digits {-7,-7,-7} -> p=+65408 (17'h0FF80); a=127, digits {+7,+7,+7} -> p=64897.
REQ-037 a=-3, digits {sign1 mag0, +1, -1} -> p=+168; "-0" contributes 0.
REQ-038 a=9, digits {+1,+1,+1}, dig_valid low 4 cycles before digit 1 -> p=657, p_valid delayed by exactly 4 cycles.
REQ-039 p_ready low 5 cycles in DONE -> p, p_valid stable, a_ready=0 and a_valid ignored; after p_ready, IDLE next cycle.
REQ-040 rst pulsed during DIGIT after one digit -> all outputs reset immediately; next operation a=2, digits {+1,0,0} -> p=2.

Source files
------------

// File: rtl/lut_digit_mac_if.sv
// rtl/lut_digit_mac_if.sv - multiplicand, coded-digit and product handshakes for lut_digit_mac
interface lut_digit_mac_if #(
    parameter int A_W = 8,
    parameter int ND  = 3
);
    localparam int P_W = A_W + 3 * ND;

    logic                  a_valid;
    logic                  a_ready;
    logic signed [A_W-1:0] a;
    logic                  dig_valid;
    logic                  dig_ready;
    logic [3:0]            dig;
    logic                  p_valid;
    logic                  p_ready;
    logic signed [P_W-1:0] p;
    logic                  busy;

    modport master (
        output a_valid, a, dig_valid, dig, p_ready,
        input  a_ready, dig_ready, p_valid, p, busy
    );

    modport slave (
        input  a_valid, a, dig_valid, dig, p_ready,
        output a_ready, dig_ready, p_valid, p, busy
    );
endinterface

// File: rtl/lut_digit_mac.sv
// rtl/lut_digit_mac.sv - signed multiply by radix-8 signed-magnitude digits using a built multiple table
module lut_digit_mac #(
    parameter int A_W = 8,
    parameter int ND  = 3
) (
    input  logic          clk,
    input  logic          rst,
    lut_digit_mac_if.slave bus
);
    localparam int P_W  = A_W + 3 * ND;
    localparam int L_W  = A_W + 3;
    localparam int K_W  = (ND > 1) ? $clog2(ND) : 1;
    localparam int SH_W = $clog2(3 * ND);

    typedef enum logic [1:0] {IDLE, BUILD, DIGIT, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [A_W-1:0] a_q;
    logic signed [L_W-1:0] lut [0:7];
    logic [2:0]            m_q;
    logic [K_W-1:0]        k_q;
    logic signed [P_W-1:0] acc_q;

    logic                  a_fire, dig_fire, p_fire, last_dig;
    logic signed [L_W-1:0] build_sum, sel;
    logic signed [P_W-1:0] ext, term;
    logic [SH_W-1:0]       shamt;

    assign bus.a_ready   = (state_q == IDLE);
    assign bus.dig_ready = (state_q == DIGIT);
    assign bus.p_valid   = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.p         = (state_q == DONE) ? acc_q : '0;

    assign a_fire   = bus.a_valid && bus.a_ready;
    assign dig_fire = bus.dig_valid && bus.dig_ready;
    assign p_fire   = bus.p_valid && bus.p_ready;
    assign last_dig = (k_q == K_W'(ND - 1));

    // The single table adder: each BUILD cycle adds a to the previous multiple.
    assign build_sum = lut[m_q - 3'd1] + L_W'(a_q);

    always_comb begin
        sel   = lut[bus.dig[2:0]];
        ext   = P_W'(sel);
        shamt = SH_W'(k_q) * SH_W'(3);
        term  = bus.dig[3] ? -ext : ext;
        term  = term <<< shamt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_fire) state_d = BUILD;
            BUILD:   if (m_q == 3'd7) state_d = DIGIT;
            DIGIT:   if (dig_fire && last_dig) state_d = DONE;
            DONE:    if (p_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            m_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            for (int i = 0; i < 8; i++) lut[i] <= '0;
        end else begin
            if (a_fire) begin
                a_q    <= bus.a;
                lut[0] <= '0;
                lut[1] <= L_W'(bus.a);
                m_q    <= 3'd2;
                k_q    <= '0;
                acc_q  <= '0;
            end
            if (state_q == BUILD) begin
                lut[m_q] <= build_sum;
                m_q      <= m_q + 3'd1;
            end
            if (dig_fire) begin
                acc_q <= acc_q + term;
                k_q   <= k_q + K_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lut_digit_mac.sv
// tb/tb_lut_digit_mac.sv - directed vectors for lut_digit_mac with hand-computed products
module tb_lut_digit_mac;
    localparam int A_W = 8;
    localparam int ND  = 3;
    localparam int P_W = A_W + 3 * ND;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_digit_mac_if #(.A_W(A_W), .ND(ND)) bus ();
    lut_digit_mac #(.A_W(A_W), .ND(ND)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] sp(input logic [P_W-1:0] v);
        return 32'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " a_ready"}, 32'(bus.a_ready), 32'd1);
        chk({tag, " dig_ready"}, 32'(bus.dig_ready), 32'd0);
        chk({tag, " p_valid"}, 32'(bus.p_valid), 32'd0);
        chk({tag, " p"}, sp(bus.p), 32'd0);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] av,
                         input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input int stall1, input int hold, input int exp_lat,
                         input logic [31:0] exp_p);
        logic [3:0]  dq [3];
        int          idx, st, edges, guard;
        logic        fire;
        logic [31:0] p_hold;
        dq[0] = d0; dq[1] = d1; dq[2] = d2;
        idx = 0; st = 0; edges = 0; guard = 0;
        while (!bus.a_ready && guard < 50) begin tick(); guard++; end
        chk({tag, " a_ready before"}, 32'(bus.a_ready), 32'd1);
        bus.a_valid   = 1'b1;
        bus.a         = av;
        bus.dig_valid = 1'b1;
        bus.dig       = dq[0];
        tick();
        bus.a_valid = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        while (!bus.p_valid && edges < 100) begin
            if (idx < ND) begin
                if (idx == 1 && bus.dig_ready && st < stall1) begin
                    bus.dig_valid = 1'b0;
                    st++;
                end else begin
                    bus.dig_valid = 1'b1;
                    bus.dig       = dq[idx];
                end
            end else begin
                bus.dig_valid = 1'b0;
            end
            fire = bus.dig_valid && bus.dig_ready;
            tick();
            edges++;
            if (fire) idx++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, " digits"}, 32'(idx), 32'(ND));
        chk({tag, " p"}, sp(bus.p), exp_p);
        p_hold = sp(bus.p);
        // Offer a new multiplicand and stray digits while the product waits.
        bus.a_valid   = 1'b1;
        bus.a         = 8'h55;
        bus.dig_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold p"}, sp(bus.p), p_hold);
            chk({tag, " hold p_valid"}, 32'(bus.p_valid), 32'd1);
            chk({tag, " hold a_ready"}, 32'(bus.a_ready), 32'd0);
        end
        bus.a_valid   = 1'b0;
        bus.dig_valid = 1'b0;
        bus.p_ready   = 1'b1;
        tick();
        bus.p_ready = 1'b0;
        check_idle({tag, " after"});
    endtask

    initial begin
        int guard;
        bus.a_valid = 1'b0; bus.a = '0; bus.dig_valid = 1'b0; bus.dig = '0; bus.p_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_idle("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("release a_ready", 32'(bus.a_ready), 32'd1);

        do_op("t415",   8'd5,   4'h3, 4'h2, 4'h1, 0, 0, 9,  32'd415);
        do_op("tmin",   8'h80,  4'hF, 4'hF, 4'hF, 0, 0, 9,  32'd65408);
        do_op("tmax",   8'h7F,  4'h7, 4'h7, 4'h7, 0, 0, 9,  32'd64897);
        do_op("tnegz",  8'hFD,  4'h8, 4'h1, 4'h9, 0, 0, 9,  32'd168);
        do_op("tstall", 8'd9,   4'h1, 4'h1, 4'h1, 4, 0, 13, 32'd657);
        do_op("thold",  8'd6,   4'h1, 4'h1, 4'h0, 0, 5, 9,  32'd54);

        // Abort an operation after its first digit.
        bus.a_valid = 1'b1; bus.a = 8'd7; bus.dig_valid = 1'b1; bus.dig = 4'h1;
        tick();
        bus.a_valid = 1'b0;
        guard = 0;
        while (!bus.dig_ready && guard < 20) begin tick(); guard++; end
        tick();
        chk("mid dig_ready", 32'(bus.dig_ready), 32'd1);
        chk("mid busy", 32'(bus.busy), 32'd1);
        bus.dig_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle("async rst");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("rerelease a_ready", 32'(bus.a_ready), 32'd1);

        do_op("tpost",  8'd2,   4'h1, 4'h0, 4'h0, 0, 0, 9,  32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
